// File: rtl/seq_mult_mac.sv
// seq_mult_mac: handshaked shift-add multiplier, one multiplier bit per
// enabled clock, with optional two's-complement operands and an
// accumulate mode. The result and the accumulator are 2*WIDTH bits wide.
module seq_mult_mac #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               acc_mode,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   mcand, part, acc;
  logic [WIDTH:0]  mplier;
  logic            neg, acc_mode_q, calc_last;
  logic [WIDTH:0]  mag_a, mag_b;
  logic [PW-1:0]   res_raw, res_fin;

  assign in_ready  = (state == IDLE) && ena;
  assign busy      = (state != IDLE);
  assign calc_last = (cnt == CW'(WIDTH));

  // Operand magnitudes carry one extra bit so that -2^(WIDTH-1) stays representable
  always_comb begin
    mag_a = {1'b0, a};
    mag_b = {1'b0, b};
    if (signed_mode && a[WIDTH-1]) mag_a = -{a[WIDTH-1], a};
    if (signed_mode && b[WIDTH-1]) mag_b = -{b[WIDTH-1], b};
  end

  // Result at finalisation: re-apply the sign, then add the accumulator if requested
  always_comb begin
    res_raw = neg ? -part : part;
    res_fin = acc_mode_q ? (acc + res_raw) : res_raw;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; nothing advances while ena is low
  always_comb begin
    state_nx = state;
    if (ena) begin
      case (state)
        IDLE:    if (in_valid)  state_nx = CALC;
        CALC:    if (calc_last) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath: capture on accept, one shift-add step per enabled CALC edge, then finalise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      part       <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      acc_mode_q <= 1'b0;
      product    <= '0;
      out_valid  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          // Clear takes effect before a coincident accept, so that result sees acc = 0
          if (acc_clr) acc <= '0;
          if (in_valid) begin
            mcand      <= PW'(mag_a);
            mplier     <= mag_b;
            neg        <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_mode_q <= acc_mode;
            part       <= '0;
            cnt        <= '0;
          end
        end
        CALC: begin
          if (calc_last) begin
            product   <= res_fin;
            acc       <= res_fin;
            out_valid <= 1'b1;
          end else begin
            if (mplier[0]) part <= part + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
